mem_req_arbiter: RTL and testbench

Arbitrates between the CPU instruction-fetch port and the load port and drives the single SPI memory-read engine through its level-held `start_fetch` / `fetch_done` handshake. Serializes requests, sizes each SPI read (1, 2 or 4 bytes), converts the engine's MSB-first receive word into little-endian RV32 data, and sign- or zero-extends load results. Sits between the CPU core and the SPI read engine.

---
 rtl/mem_req_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: serializes CPU fetch/load requests onto one SPI read engine, with byte reordering and load extension.
// Define MEM_REQ_FETCH_BUFFER_EN to add a one-entry fetch buffer that can answer a repeated fetch without an SPI read.
module mem_req_arbiter #(
    parameter int ADDR_W          = 24,
    parameter int RECOVERY_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_data,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_size,
    input  logic              ld_unsigned,
    output logic              ld_ack,
    output logic [31:0]       ld_data,
    output logic              mem_start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_bytes,
    input  logic [31:0]       mem_data,
    input  logic              mem_done,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RELEASE} state_t;
    state_t            state_q, state_d;
    logic              owner_ld_q, owner_ld_d, uns_q, uns_d;
    logic [3:0]        rec_q, rec_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        bytes_q, bytes_d;
    logic              start_q, start_d, busy_q, busy_d;
    logic              if_ack_q, if_ack_d, ld_ack_q, ld_ack_d;
    logic [31:0]       if_data_q, if_data_d, ld_data_q, ld_data_d;
    logic [31:0]       word, ld_ext;
    logic [15:0]       half;
`ifdef MEM_REQ_FETCH_BUFFER_EN
    logic              buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [31:0]       buf_data_q, buf_data_d;
`endif
    // The engine shifts bytes in MSB-first, so the first (lowest-address) byte ends up highest.
    assign word   = {mem_data[7:0], mem_data[15:8], mem_data[23:16], mem_data[31:24]};
    assign half   = {mem_data[7:0], mem_data[15:8]};
    assign ld_ext = bytes_q == 3'd1 ? {{24{~uns_q & mem_data[7]}}, mem_data[7:0]}
                  : bytes_q == 3'd2 ? {{16{~uns_q & half[15]}}, half} : word;

    always_comb begin
        state_d    = state_q;
        owner_ld_d = owner_ld_q;
        uns_d      = uns_q;
        rec_d      = rec_q;
        addr_d     = addr_q;
        bytes_d    = bytes_q;
        if_ack_d   = 1'b0;
        ld_ack_d   = 1'b0;
        if_data_d  = if_data_q;
        ld_data_d  = ld_data_q;
`ifdef MEM_REQ_FETCH_BUFFER_EN
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
`endif
        case (state_q)
            IDLE: if (!if_ack_q) begin
                // A buffer hit acks from IDLE; the gate above keeps the still-held request from being taken twice.
                if (ld_req) begin
                    state_d    = ISSUE;
                    owner_ld_d = 1'b1;
                    uns_d      = ld_unsigned;
                    addr_d     = ld_addr;
                    bytes_d    = ld_size == 2'd0 ? 3'd1 : ld_size == 2'd1 ? 3'd2 : 3'd4;
                end
`ifdef MEM_REQ_FETCH_BUFFER_EN
                else if (if_req && buf_valid_q && buf_addr_q == if_addr) begin
                    if_ack_d  = 1'b1;
                    if_data_d = buf_data_q;
                end
`endif
                else if (if_req) begin
                    state_d    = ISSUE;
                    owner_ld_d = 1'b0;
                    addr_d     = if_addr;
                    bytes_d    = 3'd4;
                end
            end
            ISSUE: if (mem_done) begin
                state_d = CAPTURE;
                if (owner_ld_q) begin
                    ld_ack_d  = 1'b1;
                    ld_data_d = ld_ext;
                end else begin
                    if_ack_d  = 1'b1;
                    if_data_d = word;
`ifdef MEM_REQ_FETCH_BUFFER_EN
                    buf_valid_d = 1'b1;
                    buf_addr_d  = addr_q;
                    buf_data_d  = word;
`endif
                end
            end
            CAPTURE: begin
                state_d = RELEASE;
                rec_d   = 4'(RECOVERY_CYCLES - 1);
            end
            RELEASE: if (rec_q == 4'd0) state_d = IDLE; else rec_d = rec_q - 4'd1;
            default: state_d = IDLE;
        endcase
        start_d = state_d == ISSUE;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_ld_q <= 1'b0;
            uns_q      <= 1'b0;
            rec_q      <= 4'd0;
            addr_q     <= '0;
            bytes_q    <= 3'd0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            if_ack_q   <= 1'b0;
            ld_ack_q   <= 1'b0;
            if_data_q  <= 32'd0;
            ld_data_q  <= 32'd0;
`ifdef MEM_REQ_FETCH_BUFFER_EN
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            owner_ld_q <= owner_ld_d;
            uns_q      <= uns_d;
            rec_q      <= rec_d;
            addr_q     <= addr_d;
            bytes_q    <= bytes_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            if_ack_q   <= if_ack_d;
            ld_ack_q   <= ld_ack_d;
            if_data_q  <= if_data_d;
            ld_data_q  <= ld_data_d;
`ifdef MEM_REQ_FETCH_BUFFER_EN
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
`endif
        end
    end

    assign mem_start = start_q;
    assign mem_addr  = addr_q;
    assign mem_bytes = bytes_q;
    assign busy      = busy_q;
    assign if_ack    = if_ack_q;
    assign ld_ack    = ld_ack_q;
    assign if_data   = if_data_q;
    assign ld_data   = ld_data_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: randomized bench with an engine model and a transaction-level reference for mem_req_arbiter.
module tb_mem_req_arbiter;
    localparam int AW  = 24;
    localparam int REC = 1;

    logic          clk = 1'b0, rst = 1'b1;
    logic          if_req = 1'b0, ld_req = 1'b0, ld_unsigned = 1'b0, mem_done = 1'b0;
    logic [AW-1:0] if_addr = '0, ld_addr = '0;
    logic [1:0]    ld_size = 2'd0;
    logic [31:0]   mem_data = 32'd0;
    logic          if_ack, ld_ack, mem_start, busy;
    logic [31:0]   if_data, ld_data;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_bytes;

    mem_req_arbiter #(.ADDR_W(AW), .RECOVERY_CYCLES(REC)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_unsigned(ld_unsigned),
        .ld_ack(ld_ack), .ld_data(ld_data),
        .mem_start(mem_start), .mem_addr(mem_addr), .mem_bytes(mem_bytes),
        .mem_data(mem_data), .mem_done(mem_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    int start_exp = -1, ack_exp = -1, lat = 1, eng_cnt = 0;
    logic ld_pend = 1'b0, if_pend = 1'b0, if_hit = 1'b0, prev_start = 1'b0, linger = 1'b0;
    logic [31:0] d_ld = 32'd0, d_if = 32'd0, if_exp;
    logic bv = 1'b0;
    logic [AW-1:0] ba = '0;
    logic [31:0] bd = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int nb(input logic [1:0] sz);
        return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    endfunction

    // Bytes arrive lowest address first; the last one received sits in bits [7:0].
    function automatic logic [31:0] model(input logic [31:0] d, input int n, input logic sx);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) v |= ((d >> (8 * (n - 1 - i))) & 32'hFF) << (8 * i);
        if (sx && n < 4 && v[8 * n - 1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        tick();
        if (!mem_start) begin
            mem_done = mem_done && linger;
            linger   = 1'b0;
            eng_cnt  = 0;
        end else if (!mem_done) begin
            eng_cnt++;
            if (eng_cnt >= lat) begin
                mem_done = 1'b1;
                mem_data = ld_pend ? d_ld : d_if;
                linger   = 1'($urandom_range(0, 1));
                ack_exp  = cyc + 1;
            end
        end
        if (mem_start) begin
            check("busy_issue", {31'd0, busy}, 32'd1);
            check("mem_addr", {8'd0, mem_addr}, {8'd0, ld_pend ? ld_addr : if_addr});
            check("mem_bytes", {29'd0, mem_bytes}, ld_pend ? nb(ld_size) : 4);
        end
        if (mem_start && !prev_start) check("start_cyc", cyc, start_exp);
        prev_start = mem_start;
        if (ld_ack || if_ack) check("ack_cyc", cyc, ack_exp);
        if (ld_ack) begin
            check("ld_owner", {31'd0, ld_pend}, 32'd1);
            check("ld_data", ld_data, model(d_ld, nb(ld_size), !ld_unsigned));
            ld_pend = 1'b0;
            ld_req  = 1'b0;
            if (if_pend) begin
                if_hit    = 1'b0;
                start_exp = cyc + REC + 2;
`ifdef MEM_REQ_FETCH_BUFFER_EN
                if (bv && ba == if_addr) begin
                    if_hit    = 1'b1;
                    start_exp = -1;
                    ack_exp   = cyc + REC + 2;
                end
`endif
            end
        end
        if (if_ack) begin
            if_exp = if_hit ? bd : model(d_if, 4, 1'b0);
            check("if_owner", {31'd0, if_pend}, 32'd1);
            check("if_data", if_data, if_exp);
            if (!if_hit) begin
                bv = 1'b1;
                ba = if_addr;
                bd = if_exp;
            end
            if_pend = 1'b0;
            if_req  = 1'b0;
        end
    endtask

    task automatic finish_txn();
        for (int i = 0; i < 300 && (ld_pend || if_pend || busy); i++) step();
        check("timeout", {31'd0, ld_pend || if_pend || busy}, 32'd0);
        step();
    endtask

    task automatic serve(input logic wl, input logic wi, input logic [AW-1:0] la, input logic [AW-1:0] ia,
                         input logic [1:0] sz, input logic un, input logic [31:0] dl, input logic [31:0] di,
                         input int lt);
        lat = lt; d_ld = dl; d_if = di;
        ld_req = wl; ld_addr = la; ld_size = sz; ld_unsigned = un; ld_pend = wl;
        if_req = wi; if_addr = ia; if_pend = wi;
        if_hit = 1'b0; start_exp = cyc + 1; ack_exp = -1;
`ifdef MEM_REQ_FETCH_BUFFER_EN
        if (!wl && wi && bv && ba == ia) begin
            if_hit = 1'b1; start_exp = -1; ack_exp = cyc + 1;
        end
`endif
        finish_txn();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check("rst_start", {31'd0, mem_start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_acks", {30'd0, if_ack, ld_ack}, 32'd0);
        check("rst_addr", {8'd0, mem_addr}, 32'd0);
        check("rst_bytes", {29'd0, mem_bytes}, 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_ld_data", ld_data, 32'd0);
        rst = 1'b0;
        step();
        lat = 20; d_if = 32'hDEADBEEF; if_addr = 24'h000040; if_req = 1'b1; if_pend = 1'b1;
        if_hit = 1'b0; start_exp = cyc + 1; ack_exp = -1;
        for (int i = 0; i < 10 && !mem_start; i++) step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_start", {31'd0, mem_start}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ack", {31'd0, if_ack}, 32'd0);
        lat = 3; start_exp = cyc + 1;
        finish_txn();
        serve(1'b0, 1'b1, '0, 24'h000010, 2'd0, 1'b0, 32'd0, 32'h13050500, 2);
        check("plan_if", if_data, 32'h00050513);
        serve(1'b1, 1'b0, 24'h000101, '0, 2'd0, 1'b0, 32'h00000080, 32'd0, 1);
        check("plan_lb", ld_data, 32'hFFFFFF80);
        serve(1'b1, 1'b0, 24'h000101, '0, 2'd0, 1'b1, 32'h00000080, 32'd0, 3);
        check("plan_lbu", ld_data, 32'h00000080);
        serve(1'b1, 1'b0, 24'h000202, '0, 2'd1, 1'b0, 32'h000034F2, 32'd0, 2);
        check("plan_lh", ld_data, 32'hFFFFF234);
        serve(1'b1, 1'b1, 24'h000300, 24'h000010, 2'd2, 1'b0, 32'h11223344, 32'h55667788, 2);
        check("both_ld", ld_data, 32'h44332211);
        check("both_if", if_data, 32'h88776655);
`ifdef MEM_REQ_FETCH_BUFFER_EN
        serve(1'b0, 1'b1, '0, 24'h000020, 2'd0, 1'b0, 32'd0, 32'hA1B2C3D4, 2);
        serve(1'b0, 1'b1, '0, 24'h000020, 2'd0, 1'b0, 32'd0, 32'h0BADF00D, 2);
        check("buf_hit", if_data, 32'hD4C3B2A1);
        serve(1'b0, 1'b1, '0, 24'h000024, 2'd0, 1'b0, 32'd0, 32'h01020304, 2);
        check("buf_miss", if_data, 32'h04030201);
`endif
        for (int n = 0; n < 60; n++) begin
            int kind = $urandom_range(0, 2);
            logic [AW-1:0] ia;
            case ($urandom_range(0, 3))
                0: ia = 24'h000020;
                1: ia = 24'h000024;
                2: ia = 24'h000100;
                default: ia = AW'($urandom);
            endcase
            serve(kind != 1, kind != 0, AW'($urandom), ia, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(1, 5));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
